// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver with RX FIFO and status/data registers
//
// Receives 8N1 frames (8E1 when UART_RECEIVER_PARITY_EN is defined) on rx and
// queues the bytes in a FIFO that the CPU drains through a register interface.
//
// Ports:
//   clk             sole clock, rising edge
//   reset_n         asynchronous active-low reset
//   addr            0 = status register, 1 = data register
//   write_data      status write, 1 in bits 1..3 clears the matching sticky flag
//   byte_enable     qualifies write_data
//   write_req       register write strobe
//   read_req        register read strobe
//   read_data       registered read result
//   read_data_valid one-cycle pulse qualifying read_data
//   rx              asynchronous serial input, idle high
//
// Status register: bit0 rx_valid, bit1 overrun, bit2 frame_err, bit3 parity_err.
// Optional feature macro: UART_RECEIVER_PARITY_EN (even parity bit after the data bits).

module uart_receiver #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       addr,
  input  logic [7:0] write_data,
  input  logic       byte_enable,
  input  logic       write_req,
  input  logic       read_req,
  output logic [7:0] read_data,
  output logic       read_data_valid,
  input  logic       rx
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic          rx_meta, rx_s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_bad;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          overrun, frame_err, parity_err;

  logic          stop_sample, push_req, frame_set, parity_set, overrun_set;
  logic          empty, full, do_pop, do_push;
  logic [2:0]    clr;
  logic          unused_wd;

  assign unused_wd = ^{write_data[7:4], write_data[0]};

  // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Counter is loaded with half a bit on the start edge, so every later
  // full-bit reload lands the sample point at the bit centre.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt     <= HALF_M1;
            par_bad <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state   <= S_DATA;
              cnt     <= BIT_M1;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shift   <= {rx_s, shift[7:1]};
            cnt     <= BIT_M1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_RECEIVER_PARITY_EN
        S_PARITY: begin
          if (cnt == '0) begin
            // Even parity: data ones plus parity bit must be even.
            par_bad <= (rx_s != ^shift);
            cnt     <= BIT_M1;
            state   <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Leave at the centre sample so a start edge in the second half is caught.
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stop_sample = (state == S_STOP) && (cnt == '0);
  assign push_req    = stop_sample && rx_s && !par_bad;
  assign frame_set   = stop_sample && !rx_s;
  assign parity_set  = stop_sample && rx_s && par_bad;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == PW'(DEPTH));
  assign do_pop  = read_req && addr && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_push     = push_req && (!full || do_pop);
  assign overrun_set = push_req && full && !do_pop;

  assign clr = (write_req && !addr && byte_enable) ? write_data[3:1] : 3'b000;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      overrun         <= 1'b0;
      frame_err       <= 1'b0;
      parity_err      <= 1'b0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Hardware set wins over a same-cycle software clear.
      overrun    <= overrun_set | (overrun    & ~clr[0]);
      frame_err  <= frame_set   | (frame_err  & ~clr[1]);
      parity_err <= parity_set  | (parity_err & ~clr[2]);
      read_data_valid <= read_req;
      if (read_req) begin
        if (addr) read_data <= empty ? 8'h00 : mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
        else      read_data <= {4'b0000, parity_err, frame_err, overrun, !empty};
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver

module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int FDL = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       addr;
  logic [7:0] write_data;
  logic       byte_enable;
  logic       write_req;
  logic       read_req;
  logic [7:0] read_data;
  logic       read_data_valid;
  logic       rx;

  int tests = 0;
  int fails = 0;

  uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(FDL)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .write_data(write_data),
    .byte_enable(byte_enable), .write_req(write_req), .read_req(read_req),
    .read_data(read_data), .read_data_valid(read_data_valid), .rx(rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_status;
    logic [7:0] exp_read;
    logic [7:0] clr;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reg_read(input logic a, output logic [7:0] d);
    addr = a;
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    check("rdv_high", {7'b0, read_data_valid}, 8'h01);
    d = read_data;
    tick();
    check("rdv_pulse", {7'b0, read_data_valid}, 8'h00);
  endtask

  task automatic reg_write(input logic a, input logic [7:0] d, input logic be);
    addr = a;
    write_data = d;
    byte_enable = be;
    write_req = 1'b1;
    tick();
    write_req = 1'b0;
    byte_enable = 1'b0;
    tick();
  endtask

  // action: 0 none, 1 data read at the stop sample edge, 2 clear frame_err at that edge
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                            input int action, output logic [7:0] popped);
    popped = 8'h00;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
`ifdef UART_RECEIVER_PARITY_EN
    rx = par_bit;
    repeat (CPB) tick();
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    rx = stop_bit;
    if (action == 0) begin
      repeat (CPB) tick();
    end else begin
      // Stop bit centre is sampled 11 edges after the stop level is driven (2 sync + half bit).
      repeat (10) tick();
      if (action == 1) begin
        addr = 1'b1;
        read_req = 1'b1;
      end else begin
        addr = 1'b0;
        write_data = 8'h04;
        byte_enable = 1'b1;
        write_req = 1'b1;
      end
      tick();
      read_req = 1'b0;
      write_req = 1'b0;
      byte_enable = 1'b0;
      popped = read_data;
      repeat (CPB - 11) tick();
    end
    rx = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  vec_t       vecs[4];
  logic [7:0] d, p, b, mask;
  logic       sb;
  logic [7:0] q[$];
  logic       m_ov, m_fe;

  initial begin
    reset_n = 1'b0; addr = 1'b0; write_data = '0; byte_enable = 1'b0;
    write_req = 1'b0; read_req = 1'b0; rx = 1'b1;
    repeat (3) tick();
    check("reset_read_data", read_data, 8'h00);
    check("reset_rdv", {7'b0, read_data_valid}, 8'h00);
    reset_n = 1'b1;
    tick();
    reg_read(1'b0, d); check("reset_status", d, 8'h00);

    // Single-frame vectors
    vecs[0] = '{8'hA5, 1'b1, 8'h01, 8'hA5, 8'h00};
    vecs[1] = '{8'h3C, 1'b0, 8'h04, 8'h00, 8'h04};
    vecs[2] = '{8'hFF, 1'b1, 8'h01, 8'hFF, 8'h00};
    vecs[3] = '{8'h00, 1'b1, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, ^vecs[i].data, 0, p);
      reg_read(1'b0, d); check($sformatf("vec%0d_status", i), d, vecs[i].exp_status);
      reg_read(1'b1, d); check($sformatf("vec%0d_data", i), d, vecs[i].exp_read);
      if (vecs[i].clr != 8'h00) reg_write(1'b0, vecs[i].clr, 1'b1);
      reg_read(1'b0, d); check($sformatf("vec%0d_after", i), d, 8'h00);
    end

    // Short glitch on rx is rejected
    rx = 1'b0; repeat (4) tick(); rx = 1'b1;
    repeat (3 * CPB) tick();
    reg_read(1'b0, d); check("glitch_status", d, 8'h00);

    // Overrun on fifth byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, ^8'(i), 0, p);
    reg_read(1'b0, d); check("ovr_status", d, 8'h03);
    for (int i = 1; i <= 4; i++) begin
      reg_read(1'b1, d); check($sformatf("ovr_data%0d", i), d, 8'(i));
    end
    reg_read(1'b1, d); check("ovr_empty_read", d, 8'h00);
    reg_write(1'b0, 8'h02, 1'b1);
    reg_read(1'b0, d); check("ovr_cleared", d, 8'h00);

    // byte_enable gating and ignored data-register writes
    send_frame(8'h3C, 1'b0, ^8'h3C, 0, p);
    reg_write(1'b0, 8'h04, 1'b0);
    reg_read(1'b0, d); check("be_low_no_clear", d, 8'h04);
    reg_write(1'b0, 8'h04, 1'b1);
    reg_read(1'b0, d); check("be_clear", d, 8'h00);
    send_frame(8'h9E, 1'b1, ^8'h9E, 0, p);
    reg_write(1'b1, 8'hFF, 1'b1);
    reg_read(1'b0, d); check("addr1_write_ignored", d, 8'h01);
    reg_read(1'b1, d); check("addr1_write_data", d, 8'h9E);

    // Pop in the same cycle as a push into a full FIFO
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, ^8'(i), 0, p);
    send_frame(8'h05, 1'b1, ^8'h05, 1, p);
    check("pop_at_push_data", p, 8'h01);
    reg_read(1'b0, d); check("pop_at_push_status", d, 8'h01);
    for (int i = 2; i <= 5; i++) begin
      reg_read(1'b1, d); check($sformatf("pop_at_push_data%0d", i), d, 8'(i));
    end

    // Set wins over same-cycle clear
    send_frame(8'h3C, 1'b0, ^8'h3C, 2, p);
    reg_read(1'b0, d); check("set_wins", d, 8'h04);
    reg_write(1'b0, 8'h04, 1'b1);
    reg_read(1'b0, d); check("set_wins_cleared", d, 8'h00);

`ifdef UART_RECEIVER_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0, p);
    reg_read(1'b0, d); check("parity_bad_status", d, 8'h08);
    reg_write(1'b0, 8'h08, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 0, p);
    reg_read(1'b1, d); check("parity_good_data", d, 8'h07);
    reg_read(1'b0, d); check("parity_good_status", d, 8'h00);
`endif

    // Back-to-back data reads return consecutive bytes
    send_frame(8'h5A, 1'b1, ^8'h5A, 0, p);
    send_frame(8'hC3, 1'b1, ^8'hC3, 0, p);
    addr = 1'b1; read_req = 1'b1;
    tick(); check("b2b_first", read_data, 8'h5A);
    tick(); check("b2b_second", read_data, 8'hC3);
    check("b2b_rdv", {7'b0, read_data_valid}, 8'h01);
    read_req = 1'b0;
    tick(); check("b2b_rdv_low", {7'b0, read_data_valid}, 8'h00);

    // Reset mid-frame flushes FIFO and aborts the frame
    send_frame(8'h11, 1'b1, ^8'h11, 0, p);
    rx = 1'b0; repeat (CPB) tick();
    rx = 1'b1; repeat (3 * CPB) tick();
    do_reset();
    repeat (12 * CPB) tick();
    reg_read(1'b0, d); check("midframe_reset_status", d, 8'h00);
    reg_read(1'b1, d); check("midframe_reset_data", d, 8'h00);

    // Randomized frames against a queue model
    m_ov = 1'b0; m_fe = 1'b0;
    for (int it = 0; it < 16; it++) begin
      b = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(b, sb, ^b, 0, p);
      if (!sb) m_fe = 1'b1;
      else if (q.size() == 4) m_ov = 1'b1;
      else q.push_back(b);
      if ($urandom_range(0, 1) == 1) begin
        reg_read(1'b0, d);
        check($sformatf("rand%0d_status", it), d, {5'b0, m_fe, m_ov, q.size() != 0});
        reg_read(1'b1, d);
        check($sformatf("rand%0d_data", it), d, (q.size() != 0) ? q.pop_front() : 8'h00);
      end
      if ($urandom_range(0, 3) == 0) begin
        mask = 8'($urandom);
        reg_write(1'b0, mask, 1'b1);
        if (mask[1]) m_ov = 1'b0;
        if (mask[2]) m_fe = 1'b0;
      end
    end
    reg_read(1'b0, d); check("rand_final_status", d, {5'b0, m_fe, m_ov, q.size() != 0});
    for (int i = 0; i < 5; i++) begin
      reg_read(1'b1, d);
      check($sformatf("rand_drain%0d", i), d, (q.size() != 0) ? q.pop_front() : 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
